// File: rtl/spike_raster_buffer.sv
// rtl/spike_raster_buffer.sv - per-tick MN spike binning into a FWFT raster FIFO
module spike_raster_buffer #(
  parameter int AW = 10,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          tick_in,
  input  logic          spike_a,
  input  logic          spike_b,
  input  logic          rd_en,
  output logic [15:0]   dout,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   fill_cnt,
  output logic          overflow,
  output logic [31:0]   bins_total
);

  localparam int            DEPTH    = 1 << AW;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  // Edge-detect history for the three level inputs
  logic tick_q, tick_d;
  logic a_q, a_d;
  logic b_q, b_d;

  // Bin counters
  logic [CW-1:0] cnt_a_q, cnt_a_d;
  logic [CW-1:0] cnt_b_q, cnt_b_d;

  // FIFO bookkeeping
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   fill_q, fill_d;
  logic          overflow_q, overflow_d;
  logic [31:0]   bins_q, bins_d;

  // Word storage; no reset needed because dout is gated by empty
  logic [2*CW-1:0] mem_q [DEPTH];

  logic          tick_rise, a_rise, b_rise;
  logic          bin_close;
  logic          pop, push_ok;
  logic [2*CW-1:0] bin_word;
  logic          empty_w, full_w;

  assign empty_w = (fill_q == '0);
  assign full_w  = (fill_q == FULL_CNT);

  // Rising-edge detection and the close/push/pop decisions for this cycle
  always_comb begin
    tick_rise = tick_in & ~tick_q;
    a_rise    = spike_a & ~a_q;
    b_rise    = spike_b & ~b_q;
    bin_close = enable & tick_rise;
    bin_word  = {cnt_b_q, cnt_a_q};
    pop       = rd_en & ~empty_w;
    // When full, a push only fits if a pop frees a slot at the same edge
    push_ok   = bin_close & (~full_w | pop);
  end

  // Edge registers keep following their inputs even while disabled so that
  // a level already high at re-enable does not look like a fresh edge
  always_comb begin
    tick_d = tick_in;
    a_d    = spike_a;
    b_d    = spike_b;
  end

  // Per-bin spike counting; a spike on the tick edge opens the new bin at 1
  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (!enable) begin
      cnt_a_d = '0;
      cnt_b_d = '0;
    end else if (tick_rise) begin
      cnt_a_d = a_rise ? CW'(1) : '0;
      cnt_b_d = b_rise ? CW'(1) : '0;
    end else begin
      if (a_rise && (cnt_a_q != CNT_MAX)) cnt_a_d = cnt_a_q + CW'(1);
      if (b_rise && (cnt_b_q != CNT_MAX)) cnt_b_d = cnt_b_q + CW'(1);
    end
  end

  // FIFO pointers, occupancy, sticky overflow and closed-bin count
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    overflow_d = overflow_q;
    bins_d     = bins_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop)      fill_d = fill_q + (AW+1)'(1);
    else if (!push_ok && pop) fill_d = fill_q - (AW+1)'(1);
    if (bin_close && !push_ok) overflow_d = 1'b1;
    // Dropped bins still count, so the host can spot gaps in the raster
    if (bin_close) bins_d = bins_q + 32'd1;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q     <= 1'b0;
      a_q        <= 1'b0;
      b_q        <= 1'b0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      overflow_q <= 1'b0;
      bins_q     <= '0;
    end else begin
      tick_q     <= tick_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_a_q    <= cnt_a_d;
      cnt_b_q    <= cnt_b_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      overflow_q <= overflow_d;
      bins_q     <= bins_d;
    end
  end

  // Storage write; gated by reset so a bin closing during reset is discarded
  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem_q[wr_ptr_q] <= bin_word;
  end

  // Head word falls through straight from storage
  always_comb begin
    dout = 16'h0000;
    if (!empty_w) dout = 16'(mem_q[rd_ptr_q]);
  end

  assign empty      = empty_w;
  assign full       = full_w;
  assign fill_cnt   = fill_q;
  assign overflow   = overflow_q;
  assign bins_total = bins_q;

endmodule

// File: tb/tb_spike_raster_buffer.sv
// tb/tb_spike_raster_buffer.sv - self-checking bench for spike_raster_buffer
module tb_spike_raster_buffer;

  localparam int AW = 2;

  logic        clk = 1'b0;
  logic        reset, enable, tick_in, spike_a, spike_b, rd_en;
  logic [15:0] dout;
  logic        empty, full, overflow;
  logic [AW:0] fill_cnt;
  logic [31:0] bins_total;

  spike_raster_buffer #(.AW(AW), .CW(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .tick_in(tick_in),
    .spike_a(spike_a), .spike_b(spike_b), .rd_en(rd_en),
    .dout(dout), .empty(empty), .full(full), .fill_cnt(fill_cnt),
    .overflow(overflow), .bins_total(bins_total)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          na;
    int          nb;
    bit          coin;
    logic [15:0] word;
  } vec_t;

  vec_t        vecs [7];
  logic [15:0] sb [$];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic        post_tick_empty;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    sb.delete();
  endtask

  // na/nb spike pulses, then a tick; coin raises spike_a on the tick edge,
  // rd asserts rd_en on the tick edge
  task automatic run_bin(input int na, input int nb, input bit coin, input bit rd);
    int n;
    n = (na > nb) ? na : nb;
    for (int i = 0; i < n; i++) begin
      spike_a = (i < na);
      spike_b = (i < nb);
      step();
      spike_a = 1'b0;
      spike_b = 1'b0;
      step();
    end
    tick_in = 1'b1;
    spike_a = coin;
    rd_en   = rd;
    step();
    post_tick_empty = empty;
    tick_in = 1'b0;
    spike_a = 1'b0;
    rd_en   = 1'b0;
    step();
  endtask

  task automatic drain(input string nm);
    int          budget;
    logic [15:0] exp;
    budget = 16;
    while (!empty && budget > 0) begin
      exp = (sb.size() > 0) ? sb.pop_front() : 16'hDEAD;
      check(nm, {16'h0, dout}, {16'h0, exp});
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      budget--;
    end
    check({nm, " empty"}, {31'h0, empty}, 32'd1);
    check({nm, " sb_left"}, sb.size(), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] w;
    vecs[0] = '{3,   5,   1'b0, 16'h0503};
    vecs[1] = '{300, 0,   1'b0, 16'h00FF};
    vecs[2] = '{0,   0,   1'b0, 16'h0000};
    vecs[3] = '{2,   0,   1'b1, 16'h0002};
    vecs[4] = '{0,   0,   1'b0, 16'h0001};
    vecs[5] = '{7,   256, 1'b0, 16'hFF07};
    vecs[6] = '{1,   1,   1'b0, 16'h0101};

    reset = 1'b1; enable = 1'b1; tick_in = 1'b0;
    spike_a = 1'b0; spike_b = 1'b0; rd_en = 1'b0;
    step();
    check("rst empty", {31'h0, empty}, 32'd1);
    check("rst full", {31'h0, full}, 32'd0);
    check("rst fill", {29'h0, fill_cnt}, 32'd0);
    check("rst overflow", {31'h0, overflow}, 32'd0);
    check("rst bins", bins_total, 32'd0);
    check("rst dout", {16'h0, dout}, 32'd0);
    reset = 1'b0;

    // Table: one bin per vector, drained before the next
    for (int i = 0; i < 7; i++) begin
      run_bin(vecs[i].na, vecs[i].nb, vecs[i].coin, 1'b0);
      sb.push_back(vecs[i].word);
      check($sformatf("vec%0d empty_after_push", i), {31'h0, post_tick_empty}, 32'd0);
      check($sformatf("vec%0d bins", i), bins_total, i + 1);
      drain($sformatf("vec%0d word", i));
    end

    // Overflow: five bins into a four-deep FIFO
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      run_bin(k, 0, 1'b0, 1'b0);
      if (k <= 4) sb.push_back(16'(k));
    end
    check("ovf fill", {29'h0, fill_cnt}, 32'd4);
    check("ovf full", {31'h0, full}, 32'd1);
    check("ovf flag", {31'h0, overflow}, 32'd1);
    check("ovf bins", bins_total, 32'd5);
    drain("ovf word");
    check("ovf sticky", {31'h0, overflow}, 32'd1);

    // Reset mid-bin with a word stored and overflow set
    run_bin(1, 2, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      spike_a = 1'b1; step(); spike_a = 1'b0; step();
    end
    check("pre-rst fill", {29'h0, fill_cnt}, 32'd1);
    reset = 1'b1;
    step();
    check("midrst fill", {29'h0, fill_cnt}, 32'd0);
    check("midrst overflow", {31'h0, overflow}, 32'd0);
    check("midrst dout", {16'h0, dout}, 32'd0);
    check("midrst empty", {31'h0, empty}, 32'd1);
    check("midrst bins", bins_total, 32'd0);
    reset = 1'b0;
    sb.delete();
    run_bin(0, 0, 1'b0, 1'b0);
    sb.push_back(16'h0000);
    drain("midrst discard");

    // Push and pop together while full
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      run_bin(0, k, 1'b0, 1'b0);
      sb.push_back({8'(k), 8'h00});
    end
    check("simul pre full", {31'h0, full}, 32'd1);
    w = sb.pop_front();
    check("simul head", {16'h0, dout}, {16'h0, w});
    run_bin(0, 5, 1'b0, 1'b1);
    sb.push_back(16'h0500);
    check("simul fill", {29'h0, fill_cnt}, 32'd4);
    check("simul overflow", {31'h0, overflow}, 32'd0);
    check("simul bins", bins_total, 32'd5);
    drain("simul word");
    rd_en = 1'b1;
    repeat (4) step();
    rd_en = 1'b0;
    check("rd empty fill", {29'h0, fill_cnt}, 32'd0);
    check("rd empty flag", {31'h0, empty}, 32'd1);

    // Disabled: ticks and spikes ignored
    do_reset();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) run_bin(1, 1, 1'b0, 1'b0);
    check("dis bins", bins_total, 32'd0);
    check("dis empty", {31'h0, empty}, 32'd1);
    // Level already high at re-enable is not a spike
    spike_a = 1'b1;
    step();
    enable = 1'b1;
    step();
    step();
    run_bin(0, 0, 1'b1, 1'b0);
    sb.push_back(16'h0000);
    check("reen bins", bins_total, 32'd1);
    drain("reen word");

    // Push and pop together while empty: push wins
    run_bin(2, 0, 1'b0, 1'b1);
    sb.push_back(16'h0002);
    check("empty simul fill", {29'h0, fill_cnt}, 32'd1);
    drain("empty simul word");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/spike_raster_buffer.md
Name: spike_raster_buffer

Overview:
- Sits directly downstream of the two neuron_pool instances (biceps/triceps MN spike outputs).
- Bins MN spikes per sim tick and packs each bin into a 16-bit word.
- Buffers the words in a first-word-fall-through FIFO drained by a BT pipe-out endpoint (rawspikes path), so the host can read a spike raster without losing bins between polls.

Parameters:
- AW, 10, FIFO address width; depth = 2**AW words
- CW, 8, per-muscle bin counter width; the word is two CW-bit fields, so CW must be 8

Ports:
- clk  input  1  block clock; all logic on posedge
- reset  input  1  synchronous, active-high; clears all state
- enable  input  1  1 = binning and pushing active; 0 = counters held at 0, no pushes
- tick_in  input  1  sim_clk level; each rising edge closes a bin
- spike_a  input  1  biceps MN spike level; each rising edge counts one spike
- spike_b  input  1  triceps MN spike level; each rising edge counts one spike
- rd_en  input  1  pop strobe from pipe-out ep_read
- dout  output  16  FIFO head word {cnt_b[7:0], cnt_a[7:0]}; valid when empty=0
- empty  output  1  FIFO holds 0 words
- full  output  1  FIFO holds 2**AW words
- fill_cnt  output  AW+1  words currently stored
- overflow  output  1  sticky; set when a bin is dropped because the FIFO is full
- bins_total  output  32  bins closed since reset, including dropped bins; wraps modulo 2**32

Behaviour:
- Edge detect:
  - Registers tick_q, a_q, b_q.
  - tick_rise = tick_in & ~tick_q; a_rise and b_rise are formed the same way.
  - First-cycle edges after reset are measured against the reset value 0 of the registers.
- Reset (synchronous, highest priority):
  - cnt_a, cnt_b, edge registers, FIFO pointers, fill_cnt, overflow and bins_total all go to 0.
  - empty=1, full=0, dout=16'h0000.
  - A bin in progress is discarded.
- Binning (enable=1):
  - No tick_rise: a_rise increments cnt_a, saturating at 255; same for b_rise and cnt_b.
  - tick_rise cycle:
    - Push word {cnt_b, cnt_a}, with values as they were before this edge.
    - Next-cycle value of cnt_a = a_rise ? 1 : 0; same rule for cnt_b. A spike coincident with the tick belongs to the new bin.
    - bins_total increments.
- enable=0:
  - cnt_a and cnt_b forced to 0; tick_rise ignored (no push, no bins_total increment).
  - Edge registers still track their inputs, so a level already high at re-enable is not counted.
  - Reads continue normally.
- FIFO (FWFT):
  - dout shows the head word combinationally from storage whenever empty=0.
  - rd_en=1 and empty=0: pop at the clock edge; the next word appears the following cycle.
  - rd_en while empty: ignored; no pointer change, no error flag.
  - Push while full and no pop: word dropped, overflow<=1, pointers unchanged.
  - Push and pop in the same cycle while full: both succeed; fill_cnt unchanged; no overflow.
  - Push and pop in the same cycle while empty: pop ignored, push succeeds; fill_cnt becomes 1.
  - Latency: the word pushed at edge N is visible on dout and empty deasserts after edge N (one cycle, FIFO was empty).
  - Pointers are AW bits and wrap modulo 2**AW.
  - fill_cnt = pushes − pops, range 0 to 2**AW.
  - full = (fill_cnt == 2**AW); empty = (fill_cnt == 0).
- Storage: inferred block RAM is allowed, but the read path must keep the FWFT timing above, e.g. a head register that is prefetched.

Test Plan:
- Reset, then 3 spike_a and 5 spike_b rising edges, then a tick rise → one word 16'h0503; empty=0 one cycle after the push edge; bins_total=1.
- 300 spike_a edges in one bin → word 16'h00FF (saturation); the next bin starts from 0.
- spike_a and tick rise in the same cycle, with 2 prior spike_a edges → word 16'h0002; the next bin word (no more spikes) is 16'h0001.
- AW=2: 5 ticks with no reads → fill_cnt=4, full=1, overflow=1, bins_total=5; draining 4 words gives bins 1–4 in order, then empty=1.
- Full FIFO with push and rd_en in the same cycle → fill_cnt stays 4, overflow stays 0; rd_en held high on an empty FIFO → fill_cnt stays 0.
- enable=0 with 10 tick rises → no pushes, bins_total unchanged; then assert reset mid-bin with FIFO non-empty → next cycle fill_cnt=0, overflow=0, dout=0.
